// File: rtl/video_timing_out_gen.sv
// Clocked-video output stage: programmable raster timing driven from an Avalon-ST
// pixel stream, with start-of-packet frame lock and underflow / early-SOP recovery.
module video_timing_out_gen #(
  parameter int   BPP      = 24,
  parameter int   H_ACTIVE = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACTIVE = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [BPP-1:0] din_data,
  input  logic           din_valid,
  output logic           din_ready,
  input  logic           din_startofpacket,
  input  logic           din_endofpacket,
  output logic [BPP-1:0] vid_data,
  output logic           vid_datavalid,
  output logic           vid_h_sync,
  output logic           vid_v_sync,
  output logic           vid_h,
  output logic           vid_v,
  output logic           vid_f,
  output logic           underflow,
  output logic           locked
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic {S_SYNC, S_RUN} state_t;

  state_t          r_state;
  logic [HW-1:0]   r_h_cnt;
  logic [VW-1:0]   r_v_cnt;
  logic [BPP-1:0]  r_vid_data_p1;
  logic            r_datavalid_p1;
  logic            r_hs_p1;
  logic            r_vs_p1;
  logic            r_hblank_p1;
  logic            r_vblank_p1;
  logic            r_underflow_p1;
  logic            r_locked_p1;

  logic w_h_act, w_v_act, w_active, w_origin;
  logic w_hsync, w_vsync;
  logic w_lock_start, w_run_sop_err, w_run_underrun, w_run_err, w_take;
  logic w_unused_eop;

  // EOP carries no control meaning; a framing slip shows up as an SOP mismatch.
  assign w_unused_eop = din_endofpacket;

  assign w_h_act  = int'(r_h_cnt) < H_ACTIVE;
  assign w_v_act  = int'(r_v_cnt) < V_ACTIVE;
  assign w_active = w_h_act && w_v_act;
  assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_hsync  = (int'(r_h_cnt) >= H_ACTIVE + H_FP) &&
                    (int'(r_h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
  assign w_vsync  = (int'(r_v_cnt) >= V_ACTIVE + V_FP) &&
                    (int'(r_v_cnt) <  V_ACTIVE + V_FP + V_SYNC);

  // In RUN the SOP flag must coincide exactly with the raster origin.
  assign w_lock_start   = (r_state == S_SYNC) && w_origin && din_valid && din_startofpacket;
  assign w_run_sop_err  = (r_state == S_RUN) && w_active && din_valid &&
                          (w_origin ? !din_startofpacket : din_startofpacket);
  assign w_run_underrun = (r_state == S_RUN) && w_active && !din_valid;
  assign w_run_err      = w_run_sop_err || w_run_underrun;
  assign w_take         = w_lock_start ||
                          ((r_state == S_RUN) && w_active && din_valid && !w_run_sop_err);

  always_comb begin
    din_ready = 1'b0;
    if (!reset) begin
      if (r_state == S_SYNC) din_ready = !din_startofpacket || w_origin;
      else                   din_ready = w_active && !w_run_sop_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_SYNC;
      r_h_cnt        <= '0;
      r_v_cnt        <= '0;
      r_vid_data_p1  <= '0;
      r_datavalid_p1 <= 1'b0;
      r_hs_p1        <= ~HS_POL;
      r_vs_p1        <= ~VS_POL;
      r_hblank_p1    <= 1'b1;
      r_vblank_p1    <= 1'b1;
      r_underflow_p1 <= 1'b0;
      r_locked_p1    <= 1'b0;
    end else begin
      if (r_h_cnt == H_LAST) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end

      case (r_state)
        S_SYNC:  if (w_lock_start) r_state <= S_RUN;
        S_RUN:   if (w_run_err)    r_state <= S_SYNC;
        default: r_state <= S_SYNC;
      endcase

      // Stage p1: outputs describe the counter position of the previous cycle
      r_locked_p1    <= (r_state == S_RUN) ? !w_run_err : w_lock_start;
      r_underflow_p1 <= w_run_err;
      r_vid_data_p1  <= w_take ? din_data : '0;
      r_datavalid_p1 <= w_active;
      r_hblank_p1    <= !w_h_act;
      r_vblank_p1    <= !w_v_act;
      r_hs_p1        <= w_hsync ? HS_POL : ~HS_POL;
      r_vs_p1        <= w_vsync ? VS_POL : ~VS_POL;
    end
  end

  assign vid_data      = r_vid_data_p1;
  assign vid_datavalid = r_datavalid_p1;
  assign vid_h_sync    = r_hs_p1;
  assign vid_v_sync    = r_vs_p1;
  assign vid_h         = r_hblank_p1;
  assign vid_v         = r_vblank_p1;
  assign vid_f         = 1'b0;
  assign underflow     = r_underflow_p1;
  assign locked        = r_locked_p1;

endmodule

// File: tb/tb_video_timing_out_gen.sv
// Directed bench for video_timing_out_gen on an 8x6 raster (4x3 active), with one
// instance per sync polarity sharing the same stream.
module tb_video_timing_out_gen;
  localparam int BPP = 24;

  logic           clk = 1'b0;
  logic           reset;
  logic [BPP-1:0] din_data;
  logic           din_valid, din_startofpacket, din_endofpacket;
  logic           din_ready, din_ready1;
  logic [BPP-1:0] vd0, vd1;
  logic           dv0, hs0, vs0, vh0, vv0, vf0, uf0, lk0;
  logic           dv1, hs1, vs1, vh1, vv1, vf1, uf1, lk1;

  always #5 clk = ~clk;

  video_timing_out_gen #(
    .BPP(BPP), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .din_data(din_data), .din_valid(din_valid),
    .din_ready(din_ready), .din_startofpacket(din_startofpacket),
    .din_endofpacket(din_endofpacket), .vid_data(vd0), .vid_datavalid(dv0),
    .vid_h_sync(hs0), .vid_v_sync(vs0), .vid_h(vh0), .vid_v(vv0), .vid_f(vf0),
    .underflow(uf0), .locked(lk0)
  );

  video_timing_out_gen #(
    .BPP(BPP), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .din_data(din_data), .din_valid(din_valid),
    .din_ready(din_ready1), .din_startofpacket(din_startofpacket),
    .din_endofpacket(din_endofpacket), .vid_data(vd1), .vid_datavalid(dv1),
    .vid_h_sync(hs1), .vid_v_sync(vs1), .vid_h(vh1), .vid_v(vv1), .vid_f(vf1),
    .underflow(uf1), .locked(lk1)
  );

  int checks = 0;
  int errors = 0;
  int pos    = 0;
  int last   = 0;
  logic last_rdy, last_rdy1, drop_valid;
  logic [BPP-1:0] q_data[$];
  logic           q_sop[$];
  logic           q_eop[$];
  int hs0_lo, vs0_lo, hs1_hi, vs1_hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (pos=%0d)", tag, obs, exp, last);
    end
  endtask

  task automatic push_frame(input int tag, input int n);
    for (int i = 1; i <= n; i++) begin
      q_data.push_back({8'h00, tag[7:0], 8'(i)});
      q_sop.push_back(i == 1);
      q_eop.push_back(i == n);
    end
  endtask

  // Expected pixel of frame 'tag' at raster position p (0 outside the active area).
  function automatic logic [BPP-1:0] pix(input int tag, input int p);
    int h, v;
    h = p % 8;
    v = (p / 8) % 6;
    if (h < 4 && v < 3) return {8'h00, tag[7:0], 8'(v * 4 + h + 1)};
    return '0;
  endfunction

  // Drive the queue head at the falling edge, log the handshake, advance one clock.
  task automatic step();
    if (q_data.size() > 0 && !drop_valid) begin
      din_valid = 1'b1; din_data = q_data[0];
      din_startofpacket = q_sop[0]; din_endofpacket = q_eop[0];
    end else begin
      din_valid = 1'b0; din_data = '0;
      din_startofpacket = 1'b0; din_endofpacket = 1'b0;
    end
    #1;
    last_rdy  = din_ready;
    last_rdy1 = din_ready1;
    if (din_valid && din_ready) begin
      void'(q_data.pop_front());
      void'(q_sop.pop_front());
      void'(q_eop.pop_front());
    end
    @(negedge clk);
    last = pos;
    pos++;
  endtask

  task automatic chk_rdy(input logic exp);
    chk("ready0", last_rdy, exp);
    chk("ready1", last_rdy1, exp);
  endtask

  task automatic chk_ctl(input logic exp_lk, input logic exp_uf);
    chk("locked0", lk0, exp_lk);
    chk("locked1", lk1, exp_lk);
    chk("underflow0", uf0, exp_uf);
    chk("underflow1", uf1, exp_uf);
  endtask

  task automatic chk_raster(input logic [BPP-1:0] exp_pix);
    int h, v;
    logic act, hs, vs;
    h = last % 8;
    v = (last / 8) % 6;
    act = (h < 4) && (v < 3);
    hs = (h == 5) || (h == 6);
    vs = (v == 4);
    chk("datavalid0", dv0, act);
    chk("datavalid1", dv1, act);
    chk("vid_h0", vh0, !(h < 4));
    chk("vid_h1", vh1, !(h < 4));
    chk("vid_v0", vv0, !(v < 3));
    chk("vid_v1", vv1, !(v < 3));
    chk("hsync0", hs0, !hs);
    chk("hsync1", hs1, hs);
    chk("vsync0", vs0, !vs);
    chk("vsync1", vs1, vs);
    chk("vid_f", {vf1, vf0}, 2'b00);
    chk("vid_data0", vd0, exp_pix);
    chk("vid_data1", vd1, exp_pix);
  endtask

  task automatic chk_reset();
    chk("rst_data", vd0, 24'h0);
    chk("rst_datavalid", dv0, 1'b0);
    chk("rst_vid_h", vh0, 1'b1);
    chk("rst_vid_v", vv0, 1'b1);
    chk("rst_hsync0", hs0, 1'b1);
    chk("rst_vsync0", vs0, 1'b1);
    chk("rst_hsync1", hs1, 1'b0);
    chk("rst_vsync1", vs1, 1'b0);
    chk("rst_vid_f", vf0, 1'b0);
    chk_ctl(1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; drop_valid = 1'b0;
    din_valid = 1'b0; din_data = '0; din_startofpacket = 1'b0; din_endofpacket = 1'b0;
    @(negedge clk);
    repeat (3) step();
    chk_reset();

    // Stream joins mid-frame: 5 orphan beats, then frames 0 and 1.
    for (int i = 0; i < 5; i++) begin
      q_data.push_back(24'hAA0000 | 24'(i));
      q_sop.push_back(1'b0);
      q_eop.push_back(1'b0);
    end
    push_frame(0, 12);
    push_frame(1, 12);
    reset = 1'b0;
    pos = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_rdy(1'b1);
      chk_raster('0);
      chk_ctl(1'b0, 1'b0);
    end
    chk("junk_dropped", q_data.size(), 24);
    for (int i = 5; i < 48; i++) begin
      step();
      chk_rdy(1'b0);
      chk_raster('0);
      chk_ctl(1'b0, 1'b0);
    end

    // Frame 0, fully streamed: lock at (0,0) and count sync widths.
    hs0_lo = 0; vs0_lo = 0; hs1_hi = 0; vs1_hi = 0;
    for (int i = 48; i < 96; i++) begin
      step();
      chk_raster(pix(0, last));
      chk_ctl(1'b1, 1'b0);
      if (!hs0) hs0_lo++;
      if (!vs0) vs0_lo++;
      if (hs1)  hs1_hi++;
      if (vs1)  vs1_hi++;
    end
    chk("hsync0_low_count", hs0_lo, 12);
    chk("vsync0_low_count", vs0_lo, 8);
    chk("hsync1_high_count", hs1_hi, 12);
    chk("vsync1_high_count", vs1_hi, 8);

    // Frame 1 with valid dropped at (2,1); the rest of it is discarded.
    push_frame(2, 5);
    push_frame(3, 12);
    for (int i = 96; i < 144; i++) begin
      drop_valid = (pos == 106);
      step();
      drop_valid = 1'b0;
      chk_raster(last < 106 ? pix(1, last) : 24'h0);
      chk_ctl(last < 106, last == 106);
      if (last == 107) chk_rdy(1'b1);
    end
    chk("discard_tail", q_data.size(), 17);

    // Frame 2 is short: frame 3's SOP shows up at pixel 6 and is held to the next origin.
    for (int i = 144; i < 192; i++) begin
      step();
      chk_raster(last < 153 ? pix(2, last) : 24'h0);
      chk_ctl(last < 153, last == 153);
      if (last >= 153) chk_rdy(1'b0);
    end

    // Frame 3 relocks on the held SOP; reset lands at h=3, v=2.
    push_frame(4, 12);
    for (int i = 192; i < 211; i++) begin
      step();
      chk_raster(pix(3, last));
      chk_ctl(1'b1, 1'b0);
    end
    chk("first_of_frame3", pix(3, 192), 24'h000301);
    reset = 1'b1;
    step();
    chk_reset();
    step();
    reset = 1'b0;
    pos = 0;

    // Leftover beat 12 of frame 3 is discarded, frame 4 locks one raster frame later.
    step();
    chk_rdy(1'b1);
    chk_ctl(1'b0, 1'b0);
    chk_raster('0);
    for (int i = 1; i < 48; i++) begin
      step();
      chk_rdy(1'b0);
      chk_ctl(1'b0, 1'b0);
    end
    for (int i = 48; i < 64; i++) begin
      step();
      chk_raster(pix(4, last));
      chk_ctl(1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timing_out_gen.md
Name: video_timing_out_gen

Overview:
- Parametrised clocked-video output stage that replaces the fixed-mode VIP interface-timing block on the 65 MHz pixel clock.
- Consumes an Avalon-ST pixel stream carrying one frame per packet.
- Generates programmable-resolution raster timing and drives the VGA DAC path.
- Adds frame lock/resync on start-of-packet, underflow and early-SOP recovery, and selectable sync polarity.

Parameters:
- BPP, 24, pixel data width in bits.
- H_ACTIVE, 1024, active pixels per line.
- H_FP, 24, horizontal front porch in clocks.
- H_SYNC, 136, horizontal sync width in clocks.
- H_BP, 160, horizontal back porch in clocks.
- V_ACTIVE, 768, active lines per frame.
- V_FP, 3, vertical front porch in lines.
- V_SYNC, 6, vertical sync width in lines.
- V_BP, 29, vertical back porch in lines.
- HS_POL, 0, h_sync active level (0 = active low).
- VS_POL, 0, v_sync active level (0 = active low).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- din_data  in  BPP  stream pixel.
- din_valid  in  1  stream valid.
- din_ready  out  1  stream ready (combinational).
- din_startofpacket  in  1  first pixel of frame.
- din_endofpacket  in  1  last pixel of frame.
- vid_data  out  BPP  pixel to DAC.
- vid_datavalid  out  1  active-region flag.
- vid_h_sync  out  1  horizontal sync, HS_POL level when asserted.
- vid_v_sync  out  1  vertical sync, VS_POL level when asserted.
- vid_h  out  1  horizontal blanking (1 = blanking).
- vid_v  out  1  vertical blanking (1 = blanking).
- vid_f  out  1  field flag; progressive only, tied 0.
- underflow  out  1  one-cycle pulse per underflow or early-SOP event.
- locked  out  1  level; 1 while streaming in sync.

Behaviour:
- Counters: h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. v_cnt runs 0..V_TOTAL-1, same construction. v_cnt increments when h_cnt wraps to 0; both wrap to 0 together at the end of the frame. Counter widths are clog2 of the totals.
- Region order per line and per frame: active, front porch, sync, back porch.
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync is the equivalent on v_cnt, constant across the whole line.
- Reset: counters = 0; state = SYNC; vid_data = 0; vid_datavalid = 0; vid_h = vid_v = 1; syncs at inactive level (~HS_POL, ~VS_POL); vid_f = 0; underflow = 0; locked = 0. The first counter position (0,0) appears on the outputs in the cycle after reset deasserts.
- Latency: all vid_* outputs are registered and reflect the counter position of the previous cycle. A pixel transferred (valid && ready) at cycle t appears on vid_data at t+1.
- vid_datavalid, vid_h and vid_v follow the raster regardless of state. vid_data = 0 whenever no pixel was consumed for an active position.
- State machine, SYNC:
  - Head beat not SOP: din_ready = 1, beat discarded.
  - Head beat SOP, position not (0,0): din_ready = 0, SOP is held.
  - At (0,0) with valid && SOP: beat consumed as pixel (0,0); next state = RUN; locked = 1.
  - At (0,0) with no SOP at the head: stay in SYNC and output black for the rest of the frame.
- State machine, RUN:
  - din_ready = active.
  - Active position with !din_valid: underflow pulse; pixel = 0; state = SYNC; locked = 0.
  - Active position with a beat carrying SOP, other than (0,0): early-SOP error. Beat is not consumed; underflow pulse; state = SYNC; locked = 0. Because this is SYNC behaviour, the held SOP is accepted at the next (0,0).
  - At (0,0) with valid but no SOP: same handling as early SOP, but the beat is discarded by SYNC.
  - The EOP flag is ignored for control. Missing or early EOP surfaces as an SOP mismatch at the next frame.
- Simultaneous events: the underflow pulse fires at most once per cycle. Once in SYNC, further errors raise no additional pulses until locked again.
- Reset mid-frame: immediate return to the reset state next cycle; any partial frame is dropped via SYNC discard.

Test Plan:
- Params H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=0; source always valid with 12-pixel frames 0x000001..0x00000C (SOP on the first, EOP on the last). Required response:
  - locked rises at the first (0,0).
  - vid_data = 0x000001 one cycle after that (0,0) transfer.
  - h_sync low for 2 of every 8 clocks.
  - v_sync asserted for 8 clocks every 48.
  - underflow never pulses.
- Stream starts mid-frame (5 non-SOP beats, then an SOP frame) → the 5 beats are discarded with ready=1; the first output pixel is the SOP pixel at (0,0) of the following raster frame.
- din_valid dropped for 1 cycle at pixel (2,1) → one underflow pulse; vid_data = 0 at that position; locked = 0; relock at the next frame's SOP.
- SOP presented at pixel 6 of a frame → underflow pulse; the SOP beat is held (ready=0) and is output as pixel (0,0) of the next frame.
- Reset asserted at h_cnt=3, v_cnt=2 → next cycle all outputs at their reset values; locked = 0; resync on the next SOP.
- HS_POL=1, VS_POL=1 → sync pulses go high with the same timing; vid_h, vid_v and vid_datavalid are unchanged.
